systolic_2x2_sequencer: RTL and testbench

//  Control block that runs one matrix job on the 2x2 weight-stationary array (array_2_2).
//  A job is a 2x2 weight matrix, an optional bias pair and a stream of 2-element input vectors.
//  The block loads the weights, streams row-skewed activations and realigns the column-skewed results.
//  It buffers results in a small FIFO. Credit-based issue keeps the un-stallable array from overflowing it.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/seq_result_fifo.sv | 56 +++++
 rtl/systolic_2x2_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_systolic_2x2_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults, FSM state type and sizing helper for the 2x2 systolic sequencer.
package systolic_pkg;

    localparam int DW_DEF         = 8;
    localparam int ARR_LAT_DEF    = 1;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_C2,
        LOAD_C1,
        STREAM,
        DRAIN
    } seq_state_e;

    // Width able to hold every value 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/seq_result_fifo.sv
// Result FIFO of {last, Y1, Y0}; its occupancy count feeds the issue credit counter.
// Latency: written entry is visible on rd_vld/rd_dat the cycle after the write.
// Backpressure: none upstream (credits prevent overrun); write+read in one cycle is legal even when full.
module seq_result_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_fire;

    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld && rd_rdy;
    // Data bus reads as zero while empty so stale storage never shows on the port.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_vld) - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (reset)
        !(wr_vld && !rd_fire && (count == CW'(DEPTH))));

endmodule

// File: rtl/systolic_2x2_sequencer.sv
// Runs one job on array_2_2: weight load, row-skewed issue, column realign into a result FIFO.
// Latency: vector accepted at edge t is pushed in cycle t+3+ARR_LAT, y_valid one cycle later.
// Backpressure: x_ready only while credits (FIFO space minus in-flight) remain; bias via SYSTOLIC_SEQ_BIAS_EN.
module systolic_2x2_sequencer
    import systolic_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int ARR_LAT    = ARR_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [4*DW-1:0] w_data,
    input  logic [2*DW-1:0] b_data,
    input  logic            x_valid,
    output logic            x_ready,
    input  logic [2*DW-1:0] x_data,
    input  logic            x_last,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [2*DW-1:0] y_data,
    output logic            y_last,
    output logic            load,
    output logic [DW-1:0]   row_1_load,
    output logic [DW-1:0]   row_2_load,
    output logic [DW-1:0]   row_1_data,
    output logic [DW-1:0]   row_2_data,
    output logic [DW-1:0]   col_1_initial,
    output logic [DW-1:0]   col_2_initial,
    input  logic [DW-1:0]   col_1_out,
    input  logic [DW-1:0]   col_2_out
);

    localparam int L  = ARR_LAT + 3;
    localparam int CW = credit_w(FIFO_DEPTH);

    seq_state_e    state_q;
    seq_state_e    state_n;
    logic [DW-1:0] w00_q;
    logic [DW-1:0] w10_q;
    logic [DW-1:0] x1_q;
    logic [L:1]    pipe_vld;
    logic [L:1]    pipe_last;
    logic [DW-1:0] y0_a;
    logic [DW-1:0] y0_b;
    logic [DW-1:0] y1_b;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] credits;
    logic [CW-1:0] credits_n;
    logic [2*DW:0] fifo_rd_dat;
    logic          w_fire;
    logic          x_fire;
    logic          y_pop;
    logic          load_n;
    logic [DW-1:0] rl1_n;
    logic [DW-1:0] rl2_n;

    assign w_fire = w_valid && w_ready;
    assign x_fire = x_valid && x_ready;
    assign y_pop  = y_valid && y_ready;

    always_comb begin
        inflight = '0;
        for (int k = 1; k <= L; k++) begin
            inflight = inflight + CW'(pipe_vld[k]);
        end
    end

    // Next-cycle credits are exact, which lets x_ready be a plain register.
    assign credits   = CW'(FIFO_DEPTH) - fifo_count - inflight;
    assign credits_n = credits - CW'(x_fire) + CW'(y_pop);

    always_comb begin
        state_n = state_q;
        load_n  = 1'b0;
        rl1_n   = '0;
        rl2_n   = '0;
        case (state_q)
            IDLE: begin
                if (w_fire) begin
                    state_n = LOAD_C2;
                    load_n  = 1'b1;
                    rl1_n   = w_data[DW +: DW];
                    rl2_n   = w_data[3*DW +: DW];
                end
            end
            LOAD_C2: begin
                state_n = LOAD_C1;
                load_n  = 1'b1;
                rl1_n   = w00_q;
                rl2_n   = w10_q;
            end
            LOAD_C1: state_n = STREAM;
            STREAM: begin
                if (x_fire && x_last) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_vld == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            w_ready    <= 1'b0;
            x_ready    <= 1'b0;
            load       <= 1'b0;
            row_1_load <= '0;
            row_2_load <= '0;
            row_1_data <= '0;
            row_2_data <= '0;
            w00_q      <= '0;
            w10_q      <= '0;
            x1_q       <= '0;
            pipe_vld   <= '0;
            pipe_last  <= '0;
            y0_a       <= '0;
            y0_b       <= '0;
            y1_b       <= '0;
        end else begin
            state_q    <= state_n;
            w_ready    <= (state_n == IDLE);
            x_ready    <= (state_n == STREAM) && (credits_n != '0);
            load       <= load_n;
            row_1_load <= rl1_n;
            row_2_load <= rl2_n;
            if (w_fire) begin
                w00_q <= w_data[0 +: DW];
                w10_q <= w_data[2*DW +: DW];
            end
            if (x_fire) begin
                x1_q <= x_data[2*DW-1:DW];
            end
            pipe_vld   <= {pipe_vld[L-1:1], x_fire};
            pipe_last  <= {pipe_last[L-1:1], x_fire && x_last};
            row_1_data <= x_fire ? x_data[DW-1:0] : '0;
            row_2_data <= pipe_vld[1] ? x1_q : '0;
            // Column 1 finishes one cycle ahead of column 2; hold it until its partner arrives.
            if (pipe_vld[1+ARR_LAT]) begin
                y0_a <= col_1_out;
            end
            if (pipe_vld[2+ARR_LAT]) begin
                y0_b <= y0_a;
                y1_b <= col_2_out;
            end
        end
    end

`ifdef SYSTOLIC_SEQ_BIAS_EN
    logic [DW-1:0] b0_q;
    logic [DW-1:0] b1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            b0_q          <= '0;
            b1_q          <= '0;
            col_1_initial <= '0;
            col_2_initial <= '0;
        end else begin
            if (w_fire) begin
                b0_q <= b_data[DW-1:0];
                b1_q <= b_data[2*DW-1:DW];
            end
            col_1_initial <= x_fire ? b0_q : '0;
            col_2_initial <= pipe_vld[1] ? b1_q : '0;
        end
    end
`else
    logic unused_b_data;

    assign unused_b_data = ^b_data;
    assign col_1_initial = '0;
    assign col_2_initial = '0;
`endif

    seq_result_fifo #(
        .W     (2*DW + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (pipe_vld[L]),
        .wr_dat ({pipe_last[L], y1_b, y0_b}),
        .rd_rdy (y_ready),
        .rd_vld (y_valid),
        .rd_dat (fifo_rd_dat),
        .count  (fifo_count)
    );

    assign y_last = fifo_rd_dat[2*DW];
    assign y_data = fifo_rd_dat[2*DW-1:0];

endmodule

// File: tb/tb_systolic_2x2_sequencer.sv
// Directed bench for systolic_2x2_sequencer with a behavioural weight-stationary 2x2 array attached.
module tb_systolic_2x2_sequencer;

    localparam int DW = 8;
    typedef logic [2*DW:0] res_t;
    localparam logic [4*DW-1:0] W_BASE = {8'd4, 8'd3, 8'd2, 8'd1};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [4*DW-1:0] w_data = '0;
    logic [2*DW-1:0] b_data = '0;
    logic            x_valid = 1'b0;
    logic            x_ready;
    logic [2*DW-1:0] x_data = '0;
    logic            x_last = 1'b0;
    logic            y_valid;
    logic            y_ready = 1'b1;
    logic [2*DW-1:0] y_data;
    logic            y_last;
    logic            load;
    logic [DW-1:0]   row_1_load, row_2_load, row_1_data, row_2_data;
    logic [DW-1:0]   col_1_initial, col_2_initial, col_1_out, col_2_out;

    int              n_checks = 0;
    int              n_fail = 0;
    res_t            got_q[$];
    logic [2*DW-1:0] vec_q[$];
    int              x_acc = 0;
    bit              init_seen = 1'b0;

    always #5 clk = ~clk;

    systolic_2x2_sequencer dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .b_data(b_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .load(load), .row_1_load(row_1_load), .row_2_load(row_2_load),
        .row_1_data(row_1_data), .row_2_data(row_2_data),
        .col_1_initial(col_1_initial), .col_2_initial(col_2_initial),
        .col_1_out(col_1_out), .col_2_out(col_2_out)
    );

    // Weight-stationary array: weights shift column 1 -> column 2 on load,
    // activations move right, partial sums move down (bottom PE combinational).
    logic [DW-1:0] wa11, wa21, wa12, wa22, p11, p12, a1, a2;
    always @(posedge clk) begin
        if (load) begin
            wa12 <= wa11;
            wa22 <= wa21;
            wa11 <= row_1_load;
            wa21 <= row_2_load;
        end
        p11 <= col_1_initial + row_1_data * wa11;
        a1  <= row_1_data;
        p12 <= col_2_initial + a1 * wa12;
        a2  <= row_2_data;
    end
    assign col_1_out = p11 + row_2_data * wa21;
    assign col_2_out = p12 + a2 * wa22;

    always @(negedge clk) begin
        if (!reset && y_valid && y_ready) got_q.push_back({y_last, y_data});
        if (!reset && x_valid && x_ready) x_acc++;
        if (col_1_initial != '0 || col_2_initial != '0) init_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [68:0] all_outs();
        return {w_ready, x_ready, y_valid, y_last, load, row_1_load, row_2_load,
                row_1_data, row_2_data, col_1_initial, col_2_initial, y_data};
    endfunction

    function automatic res_t get_res(input int k);
        if (k < got_q.size()) return got_q[k];
        return '1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic [4*DW-1:0] w, input logic [2*DW-1:0] b);
        int guard = 0;
        w_data  = w;
        b_data  = b;
        w_valid = 1'b1;
        while (!w_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL header_handshake: w_ready=%0b, required 1", w_ready);
        end
        tick();
        w_valid = 1'b0;
    endtask

    task automatic drive_vecs(input bit mark_last);
        int idx = 0;
        int guard = 0;
        bit fire;
        while (idx < vec_q.size() && guard < 300) begin
            x_valid = 1'b1;
            x_data  = vec_q[idx];
            x_last  = mark_last && (idx == vec_q.size() - 1);
            fire    = x_ready;
            tick();
            if (fire) idx++;
            guard++;
        end
        x_valid = 1'b0;
        x_last  = 1'b0;
        x_data  = '0;
        n_checks++;
        if (idx != vec_q.size()) begin
            n_fail++;
            $display("FAIL vector_accept: accepted %0d, required %0d", idx, vec_q.size());
        end
    endtask

    task automatic wait_results(input int n);
        int guard = 0;
        while (got_q.size() < n && guard < 300) begin
            tick();
            guard++;
        end
        n_checks++;
        if (got_q.size() < n) begin
            n_fail++;
            $display("FAIL result_timeout: got %0d results, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({w_ready, x_ready, y_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b, required 100", {w_ready, x_ready, y_valid});
        end
    endtask

    task automatic test_single();
        got_q.delete();
        send_header(W_BASE, '0);
        n_checks++;
        if ({load, row_1_load, row_2_load} !== {1'b1, 8'd2, 8'd4}) begin
            n_fail++;
            $display("FAIL load_c2: got %h, required %h", {load, row_1_load, row_2_load}, {1'b1, 8'd2, 8'd4});
        end
        tick();
        n_checks++;
        if ({load, row_1_load, row_2_load} !== {1'b1, 8'd1, 8'd3}) begin
            n_fail++;
            $display("FAIL load_c1: got %h, required %h", {load, row_1_load, row_2_load}, {1'b1, 8'd1, 8'd3});
        end
        tick();
        n_checks++;
        if ({load, row_1_load, row_2_load, w_ready, x_ready} !== {1'b0, 16'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL stream_entry: got %h, required %h", {load, row_1_load, row_2_load, w_ready, x_ready}, 19'h1);
        end
        vec_q = '{{8'd0, 8'd1}};
        drive_vecs(1'b1);
        wait_results(1);
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != 1 || get_res(0) !== {1'b1, 8'd2, 8'd1}) begin
            n_fail++;
            $display("FAIL single_result: got %h (n=%0d), required %h", get_res(0), got_q.size(), {1'b1, 8'd2, 8'd1});
        end
    endtask

    task automatic test_back_to_back();
        res_t exp_r [3];
        exp_r = '{{1'b0, 8'd2, 8'd1}, {1'b0, 8'd4, 8'd3}, {1'b1, 8'd6, 8'd4}};
        got_q.delete();
        send_header(W_BASE, '0);
        vec_q = '{{8'd0, 8'd1}, {8'd1, 8'd0}, {8'd1, 8'd1}};
        drive_vecs(1'b1);
        wait_results(3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (get_res(k) !== exp_r[k]) begin
                n_fail++;
                $display("FAIL b2b_result%0d: got %h, required %h", k, get_res(k), exp_r[k]);
            end
        end
    endtask

    task automatic test_bias();
        res_t exp_r;
`ifdef SYSTOLIC_SEQ_BIAS_EN
        exp_r = {1'b1, 8'd4, 8'd3};
`else
        exp_r = {1'b1, 8'd2, 8'd1};
`endif
        got_q.delete();
        init_seen = 1'b0;
        send_header(W_BASE, {8'd2, 8'd2});
        vec_q = '{{8'd0, 8'd1}};
        drive_vecs(1'b1);
        wait_results(1);
        n_checks++;
        if (get_res(0) !== exp_r) begin
            n_fail++;
            $display("FAIL bias_result: got %h, required %h", get_res(0), exp_r);
        end
        n_checks++;
`ifdef SYSTOLIC_SEQ_BIAS_EN
        if (init_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL bias_seed: col_initial activity %0b, required 1", init_seen);
        end
`else
        if (init_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bias_seed: col_initial activity %0b, required 0", init_seen);
        end
`endif
    endtask

    task automatic test_wrap();
        got_q.delete();
        send_header({8'd1, 8'd1, 8'd1, 8'd1}, '0);
        vec_q = '{{8'd200, 8'd200}};
        drive_vecs(1'b1);
        wait_results(1);
        n_checks++;
        if (get_res(0) !== {1'b1, 8'd144, 8'd144}) begin
            n_fail++;
            $display("FAIL wrap_result: got %h, required %h", get_res(0), {1'b1, 8'd144, 8'd144});
        end
    endtask

    task automatic test_backpressure();
        int   acc_at_release = 0;
        logic rdy_at_release = 1'b1;
        res_t e;
        got_q.delete();
        vec_q.delete();
        for (int k = 0; k < 8; k++) vec_q.push_back({8'd1, 8'(k)});
        y_ready = 1'b0;
        send_header(W_BASE, '0);
        x_acc = 0;
        fork
            drive_vecs(1'b1);
            begin
                repeat (10) tick();
                acc_at_release = x_acc;
                rdy_at_release = x_ready;
                y_ready = 1'b1;
            end
        join
        n_checks++;
        if (acc_at_release != 4 || rdy_at_release !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_credits: accepts %0d x_ready %0b, required 4 and 0", acc_at_release, rdy_at_release);
        end
        wait_results(8);
        repeat (10) tick();
        for (int k = 0; k < 8; k++) begin
            e = {(k == 7) ? 1'b1 : 1'b0, 8'(2 * k + 4), 8'(k + 3)};
            n_checks++;
            if (get_res(k) !== e) begin
                n_fail++;
                $display("FAIL stall_result%0d: got %h, required %h", k, get_res(k), e);
            end
        end
        n_checks++;
        if (got_q.size() != 8) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, required 8", got_q.size());
        end
    endtask

    task automatic test_reset_mid_job();
        send_header(W_BASE, '0);
        vec_q = '{{8'd0, 8'd1}, {8'd1, 8'd0}};
        drive_vecs(1'b0);
        reset = 1'b1;
        tick();
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL midjob_reset_outputs: got %h, required 0", all_outs());
        end
        reset = 1'b0;
        got_q.delete();
        tick();
        n_checks++;
        if ({w_ready, x_ready, y_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL midjob_reset_ready: got %b, required 100", {w_ready, x_ready, y_valid});
        end
        send_header(W_BASE, '0);
        vec_q = '{{8'd1, 8'd1}};
        drive_vecs(1'b1);
        wait_results(1);
        repeat (10) tick();
        n_checks++;
        if (got_q.size() != 1 || get_res(0) !== {1'b1, 8'd6, 8'd4}) begin
            n_fail++;
            $display("FAIL after_reset_job: got %h (n=%0d), required %h", get_res(0), got_q.size(), {1'b1, 8'd6, 8'd4});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        repeat (5) tick();
        test_back_to_back();
        repeat (5) tick();
        test_bias();
        repeat (5) tick();
        test_wrap();
        repeat (5) tick();
        test_backpressure();
        repeat (5) tick();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
